// File: rtl/buzzer_arbiter_if.sv
// CPU-side strobe and status bundle for the buzzer arbiter.
// master = CPU/PIO side, slave = arbiter side.
interface buzzer_arbiter_if #(
  parameter int NUM_PLAYERS = 4,
  parameter int SCORE_W     = 4
);
  logic                           arm;
  logic                           abort;
  logic                           judge_valid;
  logic                           judge_correct;
  logic                           clear_scores;
  logic [1:0]                     state;
  logic                           winner_valid;
  logic [1:0]                     winner_id;
  logic [NUM_PLAYERS-1:0]         winner_onehot;
  logic [NUM_PLAYERS-1:0]         lockout;
  logic                           timeout;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;

  modport master (
    output arm, abort, judge_valid, judge_correct, clear_scores,
    input  state, winner_valid, winner_id, winner_onehot, lockout, timeout, scores
  );

  modport slave (
    input  arm, abort, judge_valid, judge_correct, clear_scores,
    output state, winner_valid, winner_id, winner_onehot, lockout, timeout, scores
  );
endinterface

// File: rtl/buzzer_arbiter.sv
// Quiz buzzer arbiter: debounced KEY inputs, round-robin grant of the
// answer slot, answer-window timer, per-player saturating scores.
module buzzer_arbiter #(
  parameter int NUM_PLAYERS     = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ANSWER_CYCLES   = 250000000,
  parameter int SCORE_W         = 4
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic [NUM_PLAYERS-1:0] buttons_n,
  buzzer_arbiter_if.slave        bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(ANSWER_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] T_LOAD  = TW'(ANSWER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ANSWER = 2'd2
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;

  logic [NUM_PLAYERS-1:0]          r_sync1;
  logic [NUM_PLAYERS-1:0]          r_sync2;
  logic [NUM_PLAYERS-1:0]          w_level;
  logic [NUM_PLAYERS-1:0]          r_deb;
  logic [NUM_PLAYERS-1:0]          r_deb_d;
  logic [NUM_PLAYERS-1:0][DW-1:0]  r_dbcnt;
  logic [NUM_PLAYERS-1:0]          w_press;

  logic [1:0]                      r_winner;
  logic [1:0]                      r_rr;
  logic [NUM_PLAYERS-1:0]          r_lockout;
  logic [TW-1:0]                   r_timer;
  logic                            r_timeout;
  logic [NUM_PLAYERS*SCORE_W-1:0]  r_scores;

  logic [NUM_PLAYERS-1:0]          w_req;
  logic                            w_grant_any;
  logic [1:0]                      w_grant_id;
  logic [2:0]                      w_sum;
  logic [2:0]                      w_rr_sum;
  logic [1:0]                      w_rr_nxt;

  logic                            w_in_answer;
  logic                            w_verdict;
  logic                            w_hit;
  logic                            w_expire;
  logic                            w_miss;
  logic [NUM_PLAYERS-1:0]          w_winner_dec;
  logic [NUM_PLAYERS-1:0]          w_lock_miss;
  logic                            w_all_locked;

  // Two-flop synchroniser on the raw active-low keys; resets to released.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= buttons_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_level = ~r_sync2;

  // Debounce: the counter runs only while the synchronised level disagrees
  // with the accepted level, so any bounce back clears it.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_deb   <= '0;
      r_deb_d <= '0;
      r_dbcnt <= '0;
    end else begin
      r_deb_d <= r_deb;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        if (w_level[i] == r_deb[i]) begin
          r_dbcnt[i] <= '0;
        end else if (r_dbcnt[i] == DB_LAST) begin
          r_deb[i]   <= w_level[i];
          r_dbcnt[i] <= '0;
        end else begin
          r_dbcnt[i] <= r_dbcnt[i] + DW'(1);
        end
      end
    end
  end

  assign w_press = r_deb & ~r_deb_d;

  // Round-robin search for the first eligible press at or above r_rr.
  always_comb begin
    w_req       = w_press & ~r_lockout;
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_sum       = '0;
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      w_sum = {1'b0, r_rr} + 3'(k);
      if (w_sum >= 3'(NUM_PLAYERS)) w_sum = w_sum - 3'(NUM_PLAYERS);
      if (!w_grant_any && w_req[w_sum[1:0]]) begin
        w_grant_any = 1'b1;
        w_grant_id  = w_sum[1:0];
      end
    end
    w_rr_sum = {1'b0, w_grant_id} + 3'd1;
    if (w_rr_sum >= 3'(NUM_PLAYERS)) w_rr_sum = '0;
    w_rr_nxt = w_rr_sum[1:0];
  end

  // Round events: verdicts, window expiry, and the lockout a miss would leave.
  always_comb begin
    w_in_answer  = (r_state == ST_ANSWER);
    w_verdict    = w_in_answer & bus.judge_valid;
    w_hit        = w_verdict & bus.judge_correct;
    w_expire     = w_in_answer & (r_timer == '0) & ~bus.judge_valid;
    w_miss       = (w_verdict & ~bus.judge_correct) | w_expire;
    w_winner_dec = NUM_PLAYERS'(1) << r_winner;
    w_lock_miss  = r_lockout | w_winner_dec;
    w_all_locked = &w_lock_miss;
  end

  // FSM state register.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  // FSM next-state; abort overrides every other event.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (bus.arm) w_state_nxt = ST_ARMED;
        ST_ARMED:  if (w_grant_any) w_state_nxt = ST_ANSWER;
        ST_ANSWER: begin
          if (w_hit)       w_state_nxt = ST_IDLE;
          else if (w_miss) w_state_nxt = w_all_locked ? ST_IDLE : ST_ARMED;
        end
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Round datapath: grant capture, answer timer, lockout and timeout pulse.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_winner  <= '0;
      r_rr      <= '0;
      r_lockout <= '0;
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire & ~bus.abort;
      if (bus.abort) begin
        r_winner  <= '0;
        r_lockout <= '0;
        r_timer   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (bus.arm) r_lockout <= '0;
          ST_ARMED: begin
            if (w_grant_any) begin
              r_winner <= w_grant_id;
              r_rr     <= w_rr_nxt;
              r_timer  <= T_LOAD;
            end
          end
          ST_ANSWER: begin
            if (r_timer != '0) r_timer <= r_timer - TW'(1);
            if (w_hit)       r_lockout <= '0;
            else if (w_miss) r_lockout <= w_all_locked ? '0 : w_lock_miss;
          end
          default: ;
        endcase
      end
    end
  end

  // Scores: clear has priority over a coincident correct verdict.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_scores <= '0;
    end else if (bus.clear_scores) begin
      r_scores <= '0;
    end else if (w_hit && !bus.abort) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        if (r_winner == 2'(i) && r_scores[i*SCORE_W +: SCORE_W] != '1)
          r_scores[i*SCORE_W +: SCORE_W] <= r_scores[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
      end
    end
  end

  // Output drive; the one-hot grant is only visible during the answer window.
  always_comb begin
    bus.state         = r_state;
    bus.winner_valid  = (r_state == ST_ANSWER);
    bus.winner_id     = r_winner;
    bus.winner_onehot = (r_state == ST_ANSWER) ? w_winner_dec : '0;
    bus.lockout       = r_lockout;
    bus.timeout       = r_timeout;
    bus.scores        = r_scores;
  end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter with short debounce/answer timings.
module tb_buzzer_arbiter;

  logic       clk;
  logic       reset_reset;
  logic [3:0] buttons_n;
  int         n_vec;
  int         n_err;

  buzzer_arbiter_if #(.NUM_PLAYERS(4), .SCORE_W(4)) bus ();

  buzzer_arbiter #(
    .NUM_PLAYERS(4),
    .DEBOUNCE_CYCLES(4),
    .ANSWER_CYCLES(10),
    .SCORE_W(4)
  ) dut (
    .clk_clk(clk),
    .reset_reset(reset_reset),
    .buttons_n(buttons_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [1:0] target);
    for (int c = 0; c < 30; c++) begin
      if (bus.state === target) break;
      @(negedge clk);
    end
    check(tag, 32'(bus.state), 32'(target));
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1; tick(1); bus.arm = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1; tick(1); bus.abort = 1'b0;
  endtask

  task automatic pulse_judge(input logic correct);
    bus.judge_valid = 1'b1; bus.judge_correct = correct;
    tick(1);
    bus.judge_valid = 1'b0; bus.judge_correct = 1'b0;
  endtask

  task automatic release_all();
    buttons_n = 4'b1111;
    tick(8);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_reset = 1'b1;
    buttons_n = 4'b1111;
    bus.arm = 1'b0; bus.abort = 1'b0; bus.judge_valid = 1'b0;
    bus.judge_correct = 1'b0; bus.clear_scores = 1'b0;
    tick(3);
    reset_reset = 1'b0;
    tick(1);

    check("rst_state", 32'(bus.state), 0);
    check("rst_wvalid", 32'(bus.winner_valid), 0);
    check("rst_wonehot", 32'(bus.winner_onehot), 0);
    check("rst_lockout", 32'(bus.lockout), 0);
    check("rst_timeout", 32'(bus.timeout), 0);
    check("rst_scores", 32'(bus.scores), 0);

    // Tie with rr_ptr=0, then again with rr_ptr=2.
    pulse_arm();
    check("tie1_armed", 32'(bus.state), 1);
    buttons_n = 4'b0101;
    wait_state("tie1_answer", 2'd2);
    check("tie1_winner", 32'(bus.winner_id), 1);
    check("tie1_onehot", 32'(bus.winner_onehot), 32'h2);
    pulse_judge(1'b1);
    release_all();
    pulse_arm();
    buttons_n = 4'b0101;
    wait_state("tie2_answer", 2'd2);
    check("tie2_winner", 32'(bus.winner_id), 3);
    pulse_judge(1'b1);
    check("tie2_idle", 32'(bus.state), 0);
    release_all();
    check("tie_scores", 32'(bus.scores), 32'h1010);

    // Wrong then right.
    pulse_arm();
    buttons_n = 4'b1110;
    wait_state("wr_p0_answer", 2'd2);
    check("wr_p0_winner", 32'(bus.winner_id), 0);
    pulse_judge(1'b0);
    check("wr_lockout", 32'(bus.lockout), 32'h1);
    check("wr_armed", 32'(bus.state), 1);
    release_all();
    buttons_n = 4'b1110;
    tick(12);
    check("wr_p0_ignored", 32'(bus.state), 1);
    release_all();
    buttons_n = 4'b1011;
    wait_state("wr_p2_answer", 2'd2);
    check("wr_p2_winner", 32'(bus.winner_id), 2);
    pulse_judge(1'b1);
    check("wr_scores", 32'(bus.scores), 32'h1110);
    check("wr_lock_clr", 32'(bus.lockout), 0);
    check("wr_idle", 32'(bus.state), 0);
    release_all();

    // Timeout: pulse 10 cycles after entering ANSWER.
    pulse_arm();
    buttons_n = 4'b1101;
    wait_state("to_answer", 2'd2);
    check("to_winner", 32'(bus.winner_id), 1);
    tick(9);
    check("to_not_yet", 32'(bus.timeout), 0);
    check("to_still_ans", 32'(bus.state), 2);
    tick(1);
    check("to_pulse", 32'(bus.timeout), 1);
    check("to_lockout", 32'(bus.lockout), 32'h2);
    check("to_armed", 32'(bus.state), 1);
    tick(1);
    check("to_one_cycle", 32'(bus.timeout), 0);
    pulse_abort();
    check("to_abort_lock", 32'(bus.lockout), 0);
    release_all();

    // Verdict coincident with expiry: no timeout pulse.
    pulse_arm();
    buttons_n = 4'b1101;
    wait_state("tj_answer", 2'd2);
    tick(9);
    pulse_judge(1'b0);
    check("tj_no_timeout", 32'(bus.timeout), 0);
    check("tj_lockout", 32'(bus.lockout), 32'h2);
    check("tj_armed", 32'(bus.state), 1);
    pulse_abort();
    release_all();

    // Saturation: 16 correct verdicts for player 3.
    for (int r = 0; r < 16; r++) begin
      pulse_arm();
      buttons_n = 4'b0111;
      wait_state("sat_answer", 2'd2);
      check("sat_winner", 32'(bus.winner_id), 3);
      pulse_judge(1'b1);
      release_all();
    end
    check("sat_scores", 32'(bus.scores), 32'hF110);

    // Judge outside ANSWER is ignored.
    pulse_judge(1'b1);
    check("idle_judge_scores", 32'(bus.scores), 32'hF110);
    check("idle_judge_state", 32'(bus.state), 0);

    // Abort during ARMED keeps scores.
    pulse_arm();
    check("ab_armed", 32'(bus.state), 1);
    pulse_abort();
    check("ab_idle", 32'(bus.state), 0);
    check("ab_scores", 32'(bus.scores), 32'hF110);

    // Clear coincident with a correct verdict: clear wins.
    pulse_arm();
    buttons_n = 4'b0111;
    wait_state("clr_answer", 2'd2);
    bus.judge_valid = 1'b1; bus.judge_correct = 1'b1; bus.clear_scores = 1'b1;
    tick(1);
    bus.judge_valid = 1'b0; bus.judge_correct = 1'b0; bus.clear_scores = 1'b0;
    check("clr_scores", 32'(bus.scores), 0);
    check("clr_idle", 32'(bus.state), 0);
    release_all();

    // Score player 0, then reset asynchronously in the middle of ANSWER.
    pulse_arm();
    buttons_n = 4'b1110;
    wait_state("p0_answer", 2'd2);
    pulse_judge(1'b1);
    check("p0_scores", 32'(bus.scores), 32'h0001);
    release_all();
    pulse_arm();
    buttons_n = 4'b1110;
    wait_state("ar_answer", 2'd2);
    #2 reset_reset = 1'b1;
    #1;
    check("ar_state", 32'(bus.state), 0);
    check("ar_wvalid", 32'(bus.winner_valid), 0);
    check("ar_wid", 32'(bus.winner_id), 0);
    check("ar_onehot", 32'(bus.winner_onehot), 0);
    check("ar_scores", 32'(bus.scores), 0);
    check("ar_lockout", 32'(bus.lockout), 0);
    @(negedge clk);
    reset_reset = 1'b0;
    buttons_n = 4'b1111;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
